// File: rtl/missile_pkg.sv
// Shared constants, colour codes and the tracer FSM state type for the missile line engine.
package missile_pkg;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOR_W  = 3;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic [2:0] BACK    = 3'b000;
    localparam logic [2:0] CITY    = 3'b010;
    localparam logic [2:0] MISSILE = 3'b101;
    localparam logic [2:0] DEFAULT = 3'b111;

    typedef enum logic [1:0] {IDLE, SETUP, STEP, FINISH} tracer_state_t;

endpackage

// File: rtl/missile_tracer.sv
// Bresenham line engine emitting one registered pixel per cycle for vga_adapter.
// Optional `MISSILE_TRACER_CLIP_EN suppresses plot for pixels outside the 320x240 screen.
module missile_tracer #(
    parameter int X_W     = missile_pkg::X_W,
    parameter int Y_W     = missile_pkg::Y_W,
    parameter int COLOR_W = missile_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     x0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y0,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               pix_stall,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               plot,
    output logic               busy,
    output logic               done
);
    import missile_pkg::*;

    // Three guard bits keep 2*err and dx-dy sums in range for full-span lines.
    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 3;
    localparam logic signed [W-1:0] ZERO = '0;

    function automatic logic signed [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? $signed(a - b) : $signed(b - a);
    endfunction

    tracer_state_t       state;
    logic [X_W-1:0]      x0_r, x1_r, cur_x;
    logic [Y_W-1:0]      y0_r, y1_r, cur_y;
    logic [COLOR_W-1:0]  color_r;
    logic                sx_neg, sy_neg;
    logic signed [W-1:0] dx, dy, err;
    logic signed [W-1:0] dx_setup, dy_setup, e2, err_next;
    logic                step_x, step_y, at_end, on_screen;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        dx_setup = abs_diff(W'(x1_r), W'(x0_r));
        dy_setup = -abs_diff(W'(y1_r), W'(y0_r));
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_next = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
        at_end   = (cur_x == x1_r) && (cur_y == y1_r);
`ifdef MISSILE_TRACER_CLIP_EN
        on_screen = (32'(cur_x) < SCREEN_W) && (32'(cur_y) < SCREEN_H);
`else
        on_screen = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            plot      <= 1'b0;
            done      <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            err       <= '0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        x0_r    <= x0;
                        y0_r    <= y0;
                        x1_r    <= x1;
                        y1_r    <= y1;
                        color_r <= cmd_color;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    dx     <= dx_setup;
                    dy     <= dy_setup;
                    err    <= dx_setup + dy_setup;
                    sx_neg <= (x1_r < x0_r);
                    sy_neg <= (y1_r < y0_r);
                    cur_x  <= x0_r;
                    cur_y  <= y0_r;
                    state  <= STEP;
                end
                STEP: begin
                    // A stalled cycle holds cur/err so the same pixel is offered again.
                    if (!pix_stall) begin
                        pix_x     <= cur_x;
                        pix_y     <= cur_y;
                        pix_color <= color_r;
                        plot      <= on_screen;
                        if (at_end) begin
                            state <= FINISH;
                        end else begin
                            err <= err_next;
                            if (step_x) cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
                            if (step_y) cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    // First FINISH cycle raises done; the second returns to IDLE so
                    // cmd_ready rises only after the done pulse.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
